// File: rtl/pcap_pkg.sv
// pcap_pkg: shared state encoding and pcap file-format constants for the capture path.
package pcap_pkg;
    typedef enum logic [2:0] {IDLE, GHDR, HDR, PAYLOAD, DONE} framer_state_t;
    localparam logic [31:0] PCAP_MAGIC    = 32'hA1B2C3D4;
    localparam logic [31:0] PCAP_VER      = 32'h00040002;
    localparam logic [31:0] PCAP_SNAPLEN  = 32'h0000FFFF;
    localparam logic [31:0] PCAP_LINKTYPE = 32'h00000001;
    localparam int HDR_WORDS  = 4;
    localparam int GHDR_WORDS = 6;
    localparam logic [31:0] USEC_MAX = 32'd999999;
    function automatic logic [31:0] ghdr_word(input logic [2:0] i);
        ghdr_word = i == 3'd0 ? PCAP_MAGIC :
                    i == 3'd1 ? PCAP_VER :
                    i == 3'd4 ? PCAP_SNAPLEN :
                    i == 3'd5 ? PCAP_LINKTYPE : 32'd0;
    endfunction
endpackage

// File: rtl/pcap_timestamp.sv
// pcap_timestamp: free-running capture clock, microsecond prescaler plus sec/usec counters.
module pcap_timestamp
    import pcap_pkg::*;
#(
    parameter int TICKS_PER_US = 50
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] ts_sec,
    output logic [31:0] ts_usec
);
    localparam int PW = TICKS_PER_US > 1 ? $clog2(TICKS_PER_US) : 1;
    logic [PW-1:0] pre;
    logic tick;
    assign tick = pre == PW'(TICKS_PER_US - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre     <= '0;
            ts_usec <= '0;
            ts_sec  <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                ts_usec <= ts_usec == USEC_MAX ? '0 : ts_usec + 1'b1;
                if (ts_usec == USEC_MAX) ts_sec <= ts_sec + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pcap_framer.sv
// pcap_framer: wraps FIFO packets as pcap records on an Avalon-ST source.
// Define PCAP_GLOBAL_HDR_EN to prepend the pcap global header once after reset.
module pcap_framer
    import pcap_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 16,
    parameter int TICKS_PER_US = 50
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_start,
    input  logic [LEN_W-1:0]  pkt_len,
    output logic              busy,
    output logic              frame_done,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_empty,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] st_data,
    output logic              st_valid,
    input  logic              st_ready,
    output logic              st_sop,
    output logic              st_eop,
    output logic [1:0]        st_empty
);
    framer_state_t state, state_nx;
    logic [2:0]       idx;
    logic [LEN_W-1:0] len_r;
    logic [31:0]      ts_sec, ts_usec, sec_r, usec_r;
    logic [LEN_W-2:0] words_left;
    logic [1:0]       last_empty;
    logic [LEN_W:0]   words_full;
    logic             xfer, start, ghdr_needed;

    pcap_timestamp #(.TICKS_PER_US(TICKS_PER_US)) u_ts (
        .clk(clk), .reset(reset), .ts_sec(ts_sec), .ts_usec(ts_usec)
    );

    assign xfer       = st_valid && st_ready;
    assign start      = state == IDLE && pkt_start;
    assign words_full = ({1'b0, pkt_len} + (LEN_W+1)'(3)) >> 2;
    assign fifo_rdreq = state == PAYLOAD && xfer;
    assign busy       = state == GHDR || state == HDR || state == PAYLOAD;
    assign frame_done = state == DONE;

`ifdef PCAP_GLOBAL_HDR_EN
    logic ghdr_sent;
    assign ghdr_needed = !ghdr_sent;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ghdr_sent <= 1'b0;
        else if (state == GHDR) ghdr_sent <= 1'b1;
    end
`else
    assign ghdr_needed = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pkt_start) state_nx = ghdr_needed ? GHDR : HDR;
`ifdef PCAP_GLOBAL_HDR_EN
            GHDR:    if (xfer && idx == 3'(GHDR_WORDS - 1)) state_nx = HDR;
`endif
            HDR:     if (xfer && idx == 3'(HDR_WORDS - 1)) state_nx = words_left != '0 ? PAYLOAD : DONE;
            PAYLOAD: if (xfer && words_left == 1) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        st_valid = 1'b0;
        st_data  = '0;
        st_sop   = 1'b0;
        st_eop   = 1'b0;
        st_empty = 2'd0;
        case (state)
`ifdef PCAP_GLOBAL_HDR_EN
            GHDR: begin
                st_valid = 1'b1;
                st_data  = DATA_W'(ghdr_word(idx));
                st_sop   = idx == 3'd0;
                st_eop   = idx == 3'(GHDR_WORDS - 1);
            end
`endif
            HDR: begin
                st_valid = 1'b1;
                st_data  = idx == 3'd0 ? DATA_W'(sec_r) : idx == 3'd1 ? DATA_W'(usec_r) : DATA_W'(len_r);
                st_sop   = idx == 3'd0;
                st_eop   = idx == 3'd3 && len_r == '0;
            end
            PAYLOAD: begin
                st_valid = !fifo_empty;
                st_data  = fifo_q;
                st_eop   = words_left == 1;
                st_empty = words_left == 1 ? last_empty : 2'd0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nx;
    end

    // idx restarts on every state change so each header section counts from 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx        <= '0;
            len_r      <= '0;
            sec_r      <= '0;
            usec_r     <= '0;
            words_left <= '0;
            last_empty <= '0;
        end else begin
            idx <= state_nx != state ? 3'd0 : xfer ? idx + 3'd1 : idx;
            if (start) begin
                len_r      <= pkt_len;
                sec_r      <= ts_sec;
                usec_r     <= ts_usec;
                words_left <= words_full[LEN_W-2:0];
                last_empty <= 2'd0 - pkt_len[1:0];
            end else if (fifo_rdreq) begin
                words_left <= words_left - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcap_framer.sv
// tb_pcap_framer: randomized self-checking bench with a frame-level reference model.
module tb_pcap_framer;
    localparam int T = 2;
    typedef struct packed {logic [31:0] d; logic sop; logic eop; logic [1:0] emp;} beat_t;

    logic clk = 0, reset = 0, pkt_start = 0, st_ready = 1, stall = 0, pop_pend = 0;
    logic [15:0] pkt_len = 0;
    logic busy, frame_done, fifo_empty, fifo_rdreq, st_valid, st_sop, st_eop;
    logic [31:0] fifo_q, st_data;
    logic [1:0] st_empty;
    logic [31:0] mem [0:1023];
    int rd_ptr = 0, wr_ptr = 0;
    int n_chk = 0, n_fail = 0, ready_mode = 0;
    int ncyc = 0, rd_cnt = 0, fd_cnt = 0, fd_neg = 0;
    longint cyc;
    bit ghdr_pending = 0, hold = 0;
    beat_t got[$];
    int got_neg[$];
    beat_t prev_b, cur_b;

    assign fifo_q     = mem[rd_ptr[9:0]];
    assign fifo_empty = (rd_ptr == wr_ptr) || stall;

    pcap_framer #(.DATA_W(32), .LEN_W(16), .TICKS_PER_US(T)) dut (
        .clk(clk), .reset(reset), .pkt_start(pkt_start), .pkt_len(pkt_len),
        .busy(busy), .frame_done(frame_done), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
        .st_sop(st_sop), .st_eop(st_eop), .st_empty(st_empty)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset)
        if (!reset) cyc <= 0;
        else cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (pop_pend) rd_ptr++;
        st_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? ~st_ready : 1'($urandom);
    end

    always @(negedge clk) begin
        ncyc++;
        pop_pend = fifo_rdreq;
        cur_b = '{st_data, st_sop, st_eop, st_empty};
        if (!reset) hold = 0;
        else begin
            if (fifo_rdreq) begin
                rd_cnt++;
                n_chk++;
                if (!(st_valid && st_ready && !fifo_empty)) begin
                    n_fail++;
                    $display("FAIL rdreq_legal valid=%b ready=%b empty=%b", st_valid, st_ready, fifo_empty);
                end
            end
            if (frame_done) begin fd_cnt++; fd_neg = ncyc; end
            if (hold && st_valid) begin
                n_chk++;
                if (cur_b !== prev_b) begin
                    n_fail++;
                    $display("FAIL stall_hold got %h want %h", cur_b, prev_b);
                end
            end
            if (st_valid && st_ready) begin got.push_back(cur_b); got_neg.push_back(ncyc); end
            hold = st_valid && !st_ready;
            prev_b = cur_b;
        end
    end

    task automatic run_pkt(input int len, input bit fixed, input bit b2b);
        beat_t exp[$];
        logic [31:0] g [6];
        longint t;
        int words, fd0, rd0, lim, n;
        logic [31:0] w;
        g = '{32'hA1B2C3D4, 32'h00040002, 32'h0, 32'h0, 32'h0000FFFF, 32'h1};
        words = (len + 3) / 4;
        @(posedge clk); #1;
        if (ghdr_pending) for (int i = 0; i < 6; i++) exp.push_back('{g[i], i == 0, i == 5, 2'd0});
        ghdr_pending = 0;
        t = cyc / T;
        exp.push_back('{32'(t / 1000000), 1'b1, 1'b0, 2'd0});
        exp.push_back('{32'(t % 1000000), 1'b0, 1'b0, 2'd0});
        exp.push_back('{32'(len), 1'b0, 1'b0, 2'd0});
        exp.push_back('{32'(len), 1'b0, len == 0, 2'd0});
        for (int i = 0; i < words; i++) begin
            w = fixed ? 32'h11111111 * (i + 1) : $urandom;
            mem[wr_ptr[9:0]] = w;
            wr_ptr++;
            exp.push_back('{w, 1'b0, i == words - 1, i == words - 1 ? 2'((4 - len % 4) % 4) : 2'd0});
        end
        got.delete(); got_neg.delete();
        fd0 = fd_cnt; rd0 = rd_cnt;
        pkt_len = 16'(len); pkt_start = 1;
        @(posedge clk); #1;
        pkt_start = 0;
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start got %b want 1", busy); end
        lim = 0;
        while (fd_cnt == fd0 && lim < 3000) begin @(posedge clk); lim++; end
        @(posedge clk); #1;
        n_chk++;
        if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL frame_done_count len=%0d got %0d want 1", len, fd_cnt - fd0); end
        n_chk++;
        if (got.size() != exp.size()) begin n_fail++; $display("FAIL beat_count len=%0d got %0d want %0d", len, got.size(), exp.size()); end
        n = got.size() < exp.size() ? got.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            n_chk++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL beat[%0d] len=%0d got d=%h sop=%b eop=%b emp=%0d want d=%h sop=%b eop=%b emp=%0d",
                         i, len, got[i].d, got[i].sop, got[i].eop, got[i].emp, exp[i].d, exp[i].sop, exp[i].eop, exp[i].emp);
            end
        end
        n_chk++;
        if (rd_cnt - rd0 != words) begin n_fail++; $display("FAIL rdreq_count len=%0d got %0d want %0d", len, rd_cnt - rd0, words); end
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done got %b want 0", busy); end
        if (got.size() > 0) begin
            n_chk++;
            if (fd_neg != got_neg[got.size() - 1] + 1) begin
                n_fail++; $display("FAIL frame_done_latency got %0d want %0d", fd_neg - got_neg[got.size() - 1], 1);
            end
            if (b2b) begin
                n_chk++;
                if (got_neg[got.size() - 1] - got_neg[0] != exp.size() - 1) begin
                    n_fail++; $display("FAIL back_to_back span got %0d want %0d", got_neg[got.size() - 1] - got_neg[0], exp.size() - 1);
                end
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_chk++;
        if ({busy, frame_done, st_valid, st_sop, st_eop, st_empty, fifo_rdreq} !== 8'd0 || st_data !== 32'd0) begin
            n_fail++;
            $display("FAIL %s got busy=%b fd=%b v=%b sop=%b eop=%b emp=%0d rd=%b d=%h want all 0",
                     tag, busy, frame_done, st_valid, st_sop, st_eop, st_empty, fifo_rdreq, st_data);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 0;
        #1;
        check_idle_outputs("async_reset_outputs");
        rd_ptr = wr_ptr;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        reset = 1;
`ifdef PCAP_GLOBAL_HDR_EN
        ghdr_pending = 1;
`else
        ghdr_pending = 0;
`endif
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_len8();
        ready_mode = 0;
        run_pkt(8, 1, 1);
    endtask

    task automatic test_lengths();
        int lens [3];
        lens = '{5, 7, 0};
        ready_mode = 0;
        for (int i = 0; i < 3; i++) run_pkt(lens[i], 0, 1);
        run_pkt(1, 0, 1);
    endtask

    task automatic test_stall();
        int r0;
        ready_mode = 1;
        r0 = rd_cnt;
        fork
            run_pkt(64, 0, 0);
            begin
                for (int i = 0; i < 500 && rd_cnt < r0 + 5; i++) @(posedge clk);
                @(posedge clk); #1;
                stall = 1;
                repeat (10) @(posedge clk);
                #1;
                stall = 0;
            end
        join
        ready_mode = 0;
    endtask

    task automatic test_random();
        ready_mode = 2;
        repeat (6) run_pkt($urandom_range(0, 60), 0, 0);
        ready_mode = 0;
    endtask

    task automatic test_busy_ignore();
        int fd0, nb;
        ready_mode = 2;
        fork
            run_pkt(12, 0, 0);
            begin
                repeat (4) @(posedge clk);
                #1; pkt_start = 1; pkt_len = 16'd99;
                @(posedge clk); #1; pkt_start = 0;
            end
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(posedge clk); #1;
                    if (frame_done) begin
                        pkt_start = 1;
                        @(posedge clk); #1;
                        pkt_start = 0;
                        break;
                    end
                end
            end
        join
        fd0 = fd_cnt; nb = got.size();
        repeat (30) @(posedge clk);
        #1;
        n_chk++;
        if (fd_cnt != fd0 || got.size() != nb || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start got frames=%0d beats=%0d busy=%b want 0 0 0", fd_cnt - fd0, got.size() - nb, busy);
        end
        ready_mode = 0;
    endtask

    task automatic test_timestamp();
        repeat (2003 + $urandom_range(0, 40)) @(posedge clk);
        run_pkt(16, 0, 1);
    endtask

    task automatic test_reset_midpacket();
        for (int i = 0; i < 10; i++) begin mem[wr_ptr[9:0]] = $urandom; wr_ptr++; end
        @(posedge clk); #1;
        pkt_len = 16'd40; pkt_start = 1;
        @(posedge clk); #1;
        pkt_start = 0;
        repeat (8) @(posedge clk);
        do_reset();
        run_pkt(4, 0, 1);
        run_pkt(4, 0, 1);
    endtask

    initial begin
        test_reset();
        test_len8();
        test_lengths();
        test_stall();
        test_random();
        test_busy_ignore();
        test_timestamp();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
